// File: rtl/seq_mult_32bit_pkg.sv
// seq_mult_32bit_pkg: shared state encodings and sizes for seq_mult_32bit.
package seq_mult_32bit_pkg;
  localparam int MULT_WIDTH = 32;
  localparam int MULT_CNT_W = 6;
  typedef enum logic [2:0] {IDLE, CALC, FIN, NEGIN, NEGOUT} state_t;
endpackage

// File: rtl/adder_32bit.sv
// adder_32bit: 32-bit adder with carry-in and signed overflow flag.
module adder_32bit (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        C0,
  output logic [31:0] SUM,
  output logic        Overflow
);
  assign SUM = A + B + {31'b0, C0};
  assign Overflow = (A[31] == B[31]) & (SUM[31] != A[31]);
endmodule

// File: rtl/seq_mult_32bit.sv
// seq_mult_32bit: shift-and-add multiplier on one shared adder_32bit.
// SEQ_MULT_SIGNED_EN adds two's-complement operands via NEGIN/NEGOUT states.
module seq_mult_32bit
  import seq_mult_32bit_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int CNT_W = MULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [63:0]      PRODUCT,
  output logic             busy,
  output logic             done
);
  state_t state, nxt;
  logic [31:0] mcand, add_a, add_b, sum;
  logic [63:0] acc;
  logic [CNT_W-1:0] cnt;
  logic add_c0, cout;
`ifdef SEQ_MULT_SIGNED_EN
  logic neg, phase, carry;
`endif
  adder_32bit u_add (.A(add_a), .B(add_b), .C0(add_c0), .SUM(sum), .Overflow());
  // The adder has no carry port, so recover it from the operand and sum MSBs.
  assign cout = (add_a[31] & add_b[31]) | ((add_a[31] ^ add_b[31]) & ~sum[31]);
  assign busy = state != IDLE;
  always_comb begin
    nxt = state;
    add_a = acc[63:32];
    add_b = acc[0] ? mcand : '0;
    add_c0 = 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
    if (state == NEGIN) begin
      add_a = ~mcand;
      add_b = '0;
      add_c0 = 1'b1;
    end else if (state == NEGOUT) begin
      add_a = phase ? ~acc[63:32] : ~acc[31:0];
      add_b = '0;
      add_c0 = phase ? carry : 1'b1;
    end
`endif
    case (state)
`ifdef SEQ_MULT_SIGNED_EN
      IDLE:   nxt = start ? NEGIN : IDLE;
      NEGIN:  nxt = CALC;
      CALC:   nxt = (cnt == CNT_W'(WIDTH - 1)) ? NEGOUT : CALC;
      NEGOUT: nxt = phase ? FIN : NEGOUT;
`else
      IDLE:   nxt = start ? CALC : IDLE;
      CALC:   nxt = (cnt == CNT_W'(WIDTH - 1)) ? FIN : CALC;
`endif
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mcand <= '0;
      acc <= '0;
      cnt <= '0;
      PRODUCT <= '0;
      done <= 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
      neg <= 1'b0;
      phase <= 1'b0;
      carry <= 1'b0;
`endif
    end else begin
      state <= nxt;
      done <= state == FIN;
      case (state)
        IDLE: if (start) begin
          mcand <= A;
          acc <= {32'b0, B};
          cnt <= '0;
`ifdef SEQ_MULT_SIGNED_EN
          neg <= A[31] ^ B[31];
          phase <= 1'b0;
`endif
        end
`ifdef SEQ_MULT_SIGNED_EN
        NEGIN: begin
          if (mcand[31]) mcand <= sum;
          if (acc[31]) acc[31:0] <= ~acc[31:0] + 32'd1;
        end
        NEGOUT: begin
          phase <= 1'b1;
          carry <= cout;
          if (neg && phase) acc[63:32] <= sum;
          if (neg && !phase) acc[31:0] <= sum;
        end
`endif
        CALC: begin
          acc <= {cout, sum, acc[31:1]};
          cnt <= cnt + CNT_W'(1);
        end
        FIN: PRODUCT <= acc;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_mult_32bit.sv
// tb_seq_mult_32bit: directed self-checking bench for seq_mult_32bit.
module tb_seq_mult_32bit;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, busy, done;
  logic [31:0] A = '0, B = '0;
  logic [63:0] PRODUCT, p, mid;
  int total = 0, passed = 0, lat, busy_n, dones;
`ifdef SEQ_MULT_SIGNED_EN
  localparam int LAT = 36;
`else
  localparam int LAT = 33;
`endif
  seq_mult_32bit dut (.clk(clk), .rst(rst), .start(start), .A(A), .B(B),
                      .PRODUCT(PRODUCT), .busy(busy), .done(done));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic run(input logic [31:0] a, input logic [31:0] b, input int poke,
                     output logic [63:0] prod, output logic [63:0] mid_p,
                     output int l, output int bn);
    A = a;
    B = b;
    start = 1'b1;
    step();
    start = 1'b0;
    l = 0;
    bn = 0;
    mid_p = 'x;
    while (!done && l < 100) begin
      bn += int'(busy);
      if (l == 5) mid_p = PRODUCT;
      start = (l == poke);
      if (l == poke) begin
        A = 32'd100;
        B = 32'd100;
      end
      step();
      l++;
    end
    start = 1'b0;
    prod = PRODUCT;
  endtask
  initial begin
    step();
    step();
    rst = 1'b0;
    chk("reset_product", PRODUCT, 64'h0);
    chk("reset_busy", {63'b0, busy}, 64'h0);
    chk("reset_done", {63'b0, done}, 64'h0);
    run(32'd3, 32'd5, -1, p, mid, lat, busy_n);
    chk("3x5", p, 64'hF);
    chk("3x5_latency", 64'(lat), 64'(LAT));
    chk("3x5_busy_cycles", 64'(busy_n), 64'(LAT));
    chk("3x5_hold_old", mid, 64'h0);
    step();
    chk("done_one_cycle", {63'b0, done}, 64'h0);
    run(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, p, mid, lat, busy_n);
`ifdef SEQ_MULT_SIGNED_EN
    chk("max_x_max", p, 64'h1);
`else
    chk("max_x_max", p, 64'hFFFF_FFFE_0000_0001);
`endif
    chk("max_hold_old", mid, 64'hF);
    run(32'h0, 32'h1234_5678, -1, p, mid, lat, busy_n);
    chk("zero_x", p, 64'h0);
    run(32'h8000_0000, 32'd2, -1, p, mid, lat, busy_n);
`ifdef SEQ_MULT_SIGNED_EN
    chk("b2b_product", p, 64'hFFFF_FFFF_0000_0000);
`else
    chk("b2b_product", p, 64'h0000_0001_0000_0000);
`endif
    chk("b2b_latency", 64'(lat), 64'(LAT));
    chk("b2b_hold_old", mid, 64'h0);
    run(32'd7, 32'd6, 10, p, mid, lat, busy_n);
    chk("repulse_product", p, 64'd42);
    chk("repulse_latency", 64'(lat), 64'(LAT));
    step();
    A = 32'd11;
    B = 32'd13;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (15) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", {63'b0, busy}, 64'h0);
    chk("abort_product", PRODUCT, 64'h0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      dones += int'(done);
      step();
    end
    chk("abort_no_done", 64'(dones), 64'h0);
    run(32'd9, 32'd9, -1, p, mid, lat, busy_n);
    chk("after_abort", p, 64'd81);
    chk("after_abort_latency", 64'(lat), 64'(LAT));
    run(32'hFFFF_FFFD, 32'd5, -1, p, mid, lat, busy_n);
`ifdef SEQ_MULT_SIGNED_EN
    chk("neg3_x5", p, 64'hFFFF_FFFF_FFFF_FFF1);
`else
    chk("neg3_x5", p, 64'h0000_0004_FFFF_FFF1);
`endif
    run(32'h8000_0000, 32'hFFFF_FFFF, -1, p, mid, lat, busy_n);
`ifdef SEQ_MULT_SIGNED_EN
    chk("min_x_neg1", p, 64'h0000_0000_8000_0000);
`else
    chk("min_x_neg1", p, 64'h7FFF_FFFF_8000_0000);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
